addr_mode_sequencer: RTL and testbench

- Parametrised operand-fetch and effective-address (EA) sequencer for the 6502 core.
- Launched by the decoder once the opcode fetch completes.
- Walks operand and pointer bytes over the 8-bit data bus, drives PC increment and the address mux, and returns a 16-bit EA with a single-cycle valid pulse.
- Covers all ten non-branch addressing modes, including indexed-indirect and indirect-indexed modes, plus page-cross penalty handling.

---
 rtl/addr_mode_sequencer_pkg.sv | 44 ++++
 rtl/addr_mode_sequencer_index_adder.sv | 22 ++
 rtl/addr_mode_sequencer.sv | 255 +++++++++++++++++++++++++
 tb/tb_addr_mode_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/addr_mode_sequencer_pkg.sv
// Shared mode codes, FSM state encoding and default build options for the operand/EA sequencer.
// Latency: none, declarations only.
// Backpressure: not applicable.
package addr_mode_sequencer_pkg;

    // Addressing-mode codes, identical to the ones the decoder emits; 10..15 are illegal
    typedef enum logic [3:0] {
        MODE_IMP   = 4'd0,
        MODE_IMM   = 4'd1,
        MODE_ZPG   = 4'd2,
        MODE_ZPG_X = 4'd3,
        MODE_ZPG_Y = 4'd4,
        MODE_ABS   = 4'd5,
        MODE_ABS_X = 4'd6,
        MODE_ABS_Y = 4'd7,
        MODE_IND_X = 4'd8,
        MODE_IND_Y = 4'd9
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_OP_LO  = 3'd1,
        ST_OP_HI  = 3'd2,
        ST_ZP_IDX = 3'd3,
        ST_PTR_LO = 3'd4,
        ST_PTR_HI = 3'd5,
        ST_FIX    = 3'd6,
        ST_DONE   = 3'd7
    } state_e;

    localparam bit DEF_ZP_WRAP      = 1'b1;
    localparam bit DEF_PAGE_PENALTY = 1'b1;
    localparam bit DEF_IDX_DUMMY    = 1'b1;

    function automatic logic mode_legal(input logic [3:0] m);
        return (m <= 4'd9);
    endfunction

    // Modes indexed by Y; every other indexed mode uses X
    function automatic logic mode_uses_y(input mode_e m);
        return (m == MODE_ZPG_Y) || (m == MODE_ABS_Y) || (m == MODE_IND_Y);
    endfunction

endpackage

// File: rtl/addr_mode_sequencer_index_adder.sv
// 8+8 index adder shared by zero-page indexing, the IND_X pointer and the page-fix path.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module ea_index_adder #(
    parameter bit ZP_WRAP = 1'b1
) (
    input  logic [7:0]  base,
    input  logic [7:0]  idx,
    output logic [7:0]  sum,
    output logic        carry,
    output logic [15:0] zp_ea
);

    logic [8:0] full;

    assign full  = {1'b0, base} + {1'b0, idx};
    assign sum   = full[7:0];
    assign carry = full[8];
    // Zero-page result either stays in page 0 or lets the carry spill into page 1
    assign zp_ea = ZP_WRAP ? {8'h00, full[7:0]} : {7'h00, full};

endmodule

// File: rtl/addr_mode_sequencer.sv
// Operand-fetch / effective-address sequencer: walks operand and pointer bytes, returns a 16-bit EA.
// Latency: 1 (IMP) to 5 cycles from start to ea_valid, plus one cycle per rdy=0 cycle.
// Backpressure: rdy=0 freezes state and bus outputs, suppresses pc_inc and ea_valid; start ignored while busy.
module addr_mode_sequencer
    import addr_mode_sequencer_pkg::*;
#(
    parameter bit ZP_WRAP      = DEF_ZP_WRAP,
    parameter bit PAGE_PENALTY = DEF_PAGE_PENALTY,
    parameter bit IDX_DUMMY    = DEF_IDX_DUMMY
) (
    input  logic        clk,
    input  logic        res,
    input  logic        rdy,
    input  logic        start,
    input  logic [3:0]  mode,
    input  logic        force_fix,
    input  logic [7:0]  data_in,
    input  logic [7:0]  x_reg,
    input  logic [7:0]  y_reg,
    output logic        pc_inc,
    output logic        addr_src,
    output logic [15:0] addr_out,
    output logic [15:0] ea,
    output logic        ea_valid,
    output logic        page_cross,
    output logic        busy,
    output logic        illegal
);

    state_e      state_q, state_d;
    mode_e       mode_q;
    logic        force_q;
    logic [7:0]  x_q, y_q;
    logic [7:0]  lo_q, hi_q, ptr_q;
    logic [15:0] ea_q;
    logic        cross_q;
    logic        illegal_q;

    logic        launch, bad_mode;
    logic        lo_ld, hi_ld, ptr_ld, ea_ld;
    logic [7:0]  ptr_val;
    logic [15:0] ea_val;
    logic        cross_val;

    logic [7:0]  add_base, add_idx, add_sum;
    logic        add_carry;
    logic [15:0] add_zp_ea;
    logic        need_fix;
    logic [7:0]  ptr_next;
    logic [7:0]  hi_bus_adj, hi_reg_adj;

    // The index joins the fetched operand byte directly when there is no dummy cycle, else the latched low byte
    assign add_base = (state_q == ST_OP_LO) ? data_in : lo_q;
    assign add_idx  = mode_uses_y(mode_q) ? y_q : x_q;

    ea_index_adder #(.ZP_WRAP(ZP_WRAP)) u_adder (
        .base  (add_base),
        .idx   (add_idx),
        .sum   (add_sum),
        .carry (add_carry),
        .zp_ea (add_zp_ea)
    );

    assign need_fix   = force_q | (add_carry & PAGE_PENALTY);
    assign ptr_next   = ptr_q + 8'd1;
    assign hi_bus_adj = data_in + {7'h00, add_carry};
    assign hi_reg_adj = hi_q + {7'h00, add_carry};

    // State register
    always_ff @(posedge clk or posedge res) begin
        if (res) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state, bus outputs and datapath load strobes; every load is gated by rdy
    always_comb begin
        state_d   = state_q;
        pc_inc    = 1'b0;
        addr_src  = 1'b0;
        addr_out  = 16'h0000;
        ea_valid  = 1'b0;
        launch    = 1'b0;
        bad_mode  = 1'b0;
        lo_ld     = 1'b0;
        hi_ld     = 1'b0;
        ptr_ld    = 1'b0;
        ptr_val   = 8'h00;
        ea_ld     = 1'b0;
        ea_val    = 16'h0000;
        cross_val = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rdy && start) begin
                    if (mode_legal(mode)) begin
                        launch  = 1'b1;
                        // IMP has no address; ea keeps the previous result
                        state_d = (mode == MODE_IMP) ? ST_DONE : ST_OP_LO;
                    end else begin
                        bad_mode = 1'b1;
                    end
                end
            end
            ST_OP_LO: begin
                pc_inc = rdy;
                if (rdy) begin
                    lo_ld = 1'b1;
                    case (mode_q)
                        MODE_IMM, MODE_ZPG: begin
                            ea_ld   = 1'b1;
                            ea_val  = {8'h00, data_in};
                            state_d = ST_DONE;
                        end
                        MODE_ZPG_X, MODE_ZPG_Y: begin
                            if (IDX_DUMMY) begin
                                state_d = ST_ZP_IDX;
                            end else begin
                                ea_ld   = 1'b1;
                                ea_val  = add_zp_ea;
                                state_d = ST_DONE;
                            end
                        end
                        MODE_IND_X: begin
                            if (IDX_DUMMY) begin
                                state_d = ST_ZP_IDX;
                            end else begin
                                ptr_ld  = 1'b1;
                                ptr_val = add_sum;
                                state_d = ST_PTR_LO;
                            end
                        end
                        MODE_IND_Y: begin
                            ptr_ld  = 1'b1;
                            ptr_val = data_in;
                            state_d = ST_PTR_LO;
                        end
                        default: state_d = ST_OP_HI;
                    endcase
                end
            end
            ST_OP_HI: begin
                pc_inc = rdy;
                if (rdy) begin
                    hi_ld = 1'b1;
                    if (mode_q == MODE_ABS) begin
                        ea_ld   = 1'b1;
                        ea_val  = {data_in, lo_q};
                        state_d = ST_DONE;
                    end else if (need_fix) begin
                        state_d = ST_FIX;
                    end else begin
                        ea_ld     = 1'b1;
                        ea_val    = {hi_bus_adj, add_sum};
                        cross_val = add_carry;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_ZP_IDX: begin
                addr_src = 1'b1;
                addr_out = {8'h00, lo_q};
                if (rdy) begin
                    if (mode_q == MODE_IND_X) begin
                        ptr_ld  = 1'b1;
                        ptr_val = add_sum;
                        state_d = ST_PTR_LO;
                    end else begin
                        ea_ld   = 1'b1;
                        ea_val  = add_zp_ea;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_PTR_LO: begin
                addr_src = 1'b1;
                addr_out = {8'h00, ptr_q};
                if (rdy) begin
                    lo_ld   = 1'b1;
                    state_d = ST_PTR_HI;
                end
            end
            ST_PTR_HI: begin
                addr_src = 1'b1;
                addr_out = {8'h00, ptr_next};
                if (rdy) begin
                    hi_ld = 1'b1;
                    if (mode_q == MODE_IND_X) begin
                        ea_ld   = 1'b1;
                        ea_val  = {data_in, lo_q};
                        state_d = ST_DONE;
                    end else if (need_fix) begin
                        state_d = ST_FIX;
                    end else begin
                        ea_ld     = 1'b1;
                        ea_val    = {hi_bus_adj, add_sum};
                        cross_val = add_carry;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_FIX: begin
                // Dummy read at the uncorrected address while the high byte is fixed up
                addr_src = 1'b1;
                addr_out = {hi_q, add_sum};
                if (rdy) begin
                    ea_ld     = 1'b1;
                    ea_val    = {hi_reg_adj, add_sum};
                    cross_val = add_carry;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                ea_valid = rdy;
                if (rdy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Launch context, fetched bytes, pointer and result registers
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            mode_q    <= MODE_IMP;
            force_q   <= 1'b0;
            x_q       <= 8'h00;
            y_q       <= 8'h00;
            lo_q      <= 8'h00;
            hi_q      <= 8'h00;
            ptr_q     <= 8'h00;
            ea_q      <= 16'h0000;
            cross_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= bad_mode;
            if (launch) begin
                mode_q  <= mode_e'(mode);
                force_q <= force_fix;
                x_q     <= x_reg;
                y_q     <= y_reg;
            end
            if (lo_ld)  lo_q  <= data_in;
            if (hi_ld)  hi_q  <= data_in;
            if (ptr_ld) ptr_q <= ptr_val;
            if (ea_ld) begin
                ea_q    <= ea_val;
                cross_q <= cross_val;
            end
        end
    end

    assign ea         = ea_q;
    assign page_cross = cross_q & ea_valid;
    assign busy       = (state_q != ST_IDLE);
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_addr_mode_sequencer.sv
// Bench for addr_mode_sequencer: memory/PC model, scoreboard of expected EAs, timing probes.
// Latency: checks start-to-ea_valid cycle counts per operation.
// Backpressure: exercises a rdy=0 stall window mid-sequence.
module tb_addr_mode_sequencer;

    logic        clk = 1'b0;
    logic        res, rdy, start, force_fix;
    logic [3:0]  mode;
    logic [7:0]  data_in, x_reg, y_reg;
    logic        pc_inc, addr_src, ea_valid, page_cross, busy, illegal;
    logic [15:0] addr_out, ea;
    logic        alt_pc_inc, alt_addr_src, alt_ea_valid, alt_page_cross, alt_busy, alt_illegal;
    logic [15:0] alt_addr_out, alt_ea;

    logic [7:0]  mem [0:65535];
    logic [15:0] pc;
    int          cyc = 0;
    int          t0 = 0;
    int          npc_cnt = 0;
    logic [16:0] cap1, cap2;
    int          done_cnt = 0;
    int          n_ops = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          alt_req = 0;
    int          alt_seen = 0;
    logic [15:0] alt_exp_ea;
    int          alt_exp_lat;

    typedef struct {
        logic [15:0] ea;
        logic        pcross;
        int          lat;
        int          npc;
        int          p1_off;
        logic [15:0] p1_addr;
        int          p2_off;
        logic [15:0] p2_addr;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    always #5 clk = ~clk;

    addr_mode_sequencer dut (
        .clk(clk), .res(res), .rdy(rdy), .start(start), .mode(mode), .force_fix(force_fix),
        .data_in(data_in), .x_reg(x_reg), .y_reg(y_reg), .pc_inc(pc_inc), .addr_src(addr_src),
        .addr_out(addr_out), .ea(ea), .ea_valid(ea_valid), .page_cross(page_cross),
        .busy(busy), .illegal(illegal)
    );

    addr_mode_sequencer #(.ZP_WRAP(1'b0), .PAGE_PENALTY(1'b1), .IDX_DUMMY(1'b0)) dut_alt (
        .clk(clk), .res(res), .rdy(rdy), .start(start), .mode(mode), .force_fix(force_fix),
        .data_in(data_in), .x_reg(x_reg), .y_reg(y_reg), .pc_inc(alt_pc_inc), .addr_src(alt_addr_src),
        .addr_out(alt_addr_out), .ea(alt_ea), .ea_valid(alt_ea_valid), .page_cross(alt_page_cross),
        .busy(alt_busy), .illegal(alt_illegal)
    );

    // Program counter model and memory bus
    always @(posedge clk or posedge res) begin
        if (res)         pc <= 16'h0200;
        else if (pc_inc) pc <= pc + 16'd1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always_comb data_in = addr_src ? mem[addr_out] : mem[pc];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push_exp(input logic [15:0] e, input logic pcr, input int lat, input int npc,
                            input int o1, input logic [15:0] a1, input int o2, input logic [15:0] a2);
        exp_t x;
        x.ea = e; x.pcross = pcr; x.lat = lat; x.npc = npc;
        x.p1_off = o1; x.p1_addr = a1; x.p2_off = o2; x.p2_addr = a2;
        sb.push_back(x);
        n_ops++;
    endtask

    task automatic put_ops(input logic [7:0] b0, input logic [7:0] b1);
        mem[pc] = b0;
        mem[pc + 16'd1] = b1;
    endtask

    task automatic send(input logic [3:0] m, input logic ff, input logic [7:0] xv, input logic [7:0] yv);
        mode = m; force_fix = ff; x_reg = xv; y_reg = yv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (done_cnt >= n_ops) break;
            @(posedge clk); #1;
        end
        check_val(tag, done_cnt, n_ops);
        if (done_cnt < n_ops) begin
            sb.delete();
            done_cnt = n_ops;
        end
    endtask

    // Scoreboard monitor: tracks each operation and compares on ea_valid
    always @(negedge clk) begin
        if (!res) begin
            if (start && !busy) begin
                t0 = cyc; npc_cnt = 0; cap1 = 17'h0; cap2 = 17'h0;
            end
            if (busy && pc_inc) npc_cnt++;
            if (busy && sb.size() > 0) begin
                if (cyc - t0 == sb[0].p1_off) cap1 = {addr_src, addr_out};
                if (cyc - t0 == sb[0].p2_off) cap2 = {addr_src, addr_out};
            end
            if (ea_valid) begin
                if (sb.size() == 0) begin
                    check_val("spurious_ea_valid", 32'd1, 32'd0);
                end else begin
                    cur = sb.pop_front();
                    check_val("ea", ea, cur.ea);
                    check_val("page_cross", page_cross, cur.pcross);
                    check_val("latency", cyc - t0, cur.lat);
                    check_val("pc_inc_count", npc_cnt, cur.npc);
                    if (cur.p1_off != 0) check_val("probe1_addr", cap1, {1'b1, cur.p1_addr});
                    if (cur.p2_off != 0) check_val("probe2_addr", cap2, {1'b1, cur.p2_addr});
                    done_cnt++;
                end
            end
        end
    end

    // Second build (no dummy cycle, 9-bit zero-page sum), checked only when armed
    always @(negedge clk) begin
        if (!res && alt_ea_valid && alt_seen < alt_req) begin
            check_val("alt_ea", alt_ea, alt_exp_ea);
            check_val("alt_latency", cyc - t0, alt_exp_lat);
            alt_seen++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res = 1'b1; rdy = 1'b1; start = 1'b0; mode = 4'd0; force_fix = 1'b0;
        x_reg = 8'h00; y_reg = 8'h00;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_busy", busy, 0);
        check_val("rst_ea", ea, 0);
        check_val("rst_addr", {addr_src, addr_out}, 0);
        check_val("rst_strobes", {pc_inc, ea_valid, page_cross, illegal}, 0);
        res = 1'b0;
        @(posedge clk); #1;

        // ABS_X with page cross, FIX dummy read at uncorrected address
        put_ops(8'hF0, 8'h12);
        push_exp(16'h1310, 1'b1, 4, 2, 3, 16'h1210, 0, 16'h0);
        send(4'd6, 1'b0, 8'h20, 8'h00);
        wait_done("abs_x_done");

        // ABS_Y without cross, then forced FIX
        put_ops(8'h00, 8'h20);
        push_exp(16'h2005, 1'b0, 3, 2, 0, 16'h0, 0, 16'h0);
        send(4'd7, 1'b0, 8'h00, 8'h05);
        wait_done("abs_y_done");
        put_ops(8'h00, 8'h20);
        push_exp(16'h2005, 1'b0, 4, 2, 3, 16'h2005, 0, 16'h0);
        send(4'd7, 1'b1, 8'h00, 8'h05);
        wait_done("abs_y_ff_done");

        // ABS_X wrapping $FFFF+1 to $0000
        put_ops(8'hFF, 8'hFF);
        push_exp(16'h0000, 1'b1, 4, 2, 3, 16'hFF00, 0, 16'h0);
        send(4'd6, 1'b0, 8'h01, 8'h00);
        wait_done("abs_x_wrap_done");

        // Zero-page indexed on both builds
        put_ops(8'hF0, 8'h00);
        push_exp(16'h0010, 1'b0, 3, 1, 2, 16'h00F0, 0, 16'h0);
        alt_exp_ea = 16'h0110; alt_exp_lat = 2; alt_req++;
        send(4'd3, 1'b0, 8'h20, 8'h00);
        wait_done("zpg_x_done");
        check_val("alt_zpg_x_done", alt_seen, alt_req);
        put_ops(8'h10, 8'h00);
        push_exp(16'h0015, 1'b0, 3, 1, 2, 16'h0010, 0, 16'h0);
        alt_exp_ea = 16'h0015; alt_exp_lat = 2; alt_req++;
        send(4'd4, 1'b0, 8'h00, 8'h05);
        wait_done("zpg_y_done");
        check_val("alt_zpg_y_done", alt_seen, alt_req);

        // IND_X with pointer wrap inside page 0
        mem[16'h00FF] = 8'h34; mem[16'h0000] = 8'h12;
        put_ops(8'hFE, 8'h00);
        push_exp(16'h1234, 1'b0, 5, 1, 3, 16'h00FF, 4, 16'h0000);
        send(4'd8, 1'b0, 8'h01, 8'h00);
        wait_done("ind_x_done");

        // IND_Y with page cross
        mem[16'h0080] = 8'hFF; mem[16'h0081] = 8'h10;
        put_ops(8'h80, 8'h00);
        push_exp(16'h1100, 1'b1, 5, 1, 2, 16'h0080, 3, 16'h0081);
        send(4'd9, 1'b0, 8'h00, 8'h01);
        wait_done("ind_y_done");

        // IND_Y with a 3-cycle stall in PTR_LO
        put_ops(8'h80, 8'h00);
        push_exp(16'h1100, 1'b1, 8, 1, 6, 16'h0081, 7, 16'h1000);
        send(4'd9, 1'b0, 8'h00, 8'h01);
        @(posedge clk); #1;
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("stall_addr", {addr_src, addr_out}, {1'b1, 16'h0080});
            check_val("stall_strobes", {pc_inc, ea_valid, busy}, 3'b001);
            @(posedge clk); #1;
        end
        rdy = 1'b1;
        wait_done("ind_y_stall_done");

        // Plain ABS and IMP
        put_ops(8'h34, 8'h12);
        push_exp(16'h1234, 1'b0, 3, 2, 0, 16'h0, 0, 16'h0);
        send(4'd5, 1'b0, 8'h00, 8'h00);
        wait_done("abs_done");
        push_exp(16'h1234, 1'b0, 1, 0, 0, 16'h0, 0, 16'h0);
        send(4'd0, 1'b0, 8'h00, 8'h00);
        wait_done("imp_done");

        // Illegal mode
        send(4'd12, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        check_val("illegal_pulse", {illegal, busy}, 2'b10);
        @(negedge clk);
        check_val("illegal_clear", {illegal, busy}, 2'b00);

        // Reset during PTR_HI of IND_Y aborts without ea_valid
        put_ops(8'h80, 8'h00);
        send(4'd9, 1'b0, 8'h00, 8'h01);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("pre_reset_ptr_hi", {addr_src, addr_out}, {1'b1, 16'h0081});
        res = 1'b1;
        #1;
        check_val("abort_busy", busy, 0);
        check_val("abort_ea", ea, 0);
        check_val("abort_addr", {addr_src, addr_out}, 0);
        check_val("abort_strobes", {pc_inc, ea_valid, page_cross, illegal}, 0);
        @(posedge clk);
        @(posedge clk); #1;
        res = 1'b0;
        @(posedge clk); #1;

        // IMM after reset
        put_ops(8'hA9, 8'h00);
        push_exp(16'h00A9, 1'b0, 2, 1, 0, 16'h0, 0, 16'h0);
        send(4'd1, 1'b0, 8'h00, 8'h00);
        wait_done("imm_done");
        check_val("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
